matrix_alu_param: RTL and testbench
===================================

Name: matrix_alu_param

Overview:
- Parametrised, memory-mapped matrix ALU on the execution-engine bus; successor to the fixed matrix-add unit.
- Holds two N×N source matrices and one result matrix in internal register banks.
- Performs ADD, SUB, matrix MULTIPLY, TRANSPOSE and SCALE under a sequencer, then exposes the result for readback over the same nRead/nWrite bus.

Parameters:
N, 4, matrix dimension (2..8); matrices are N×N.
DW, 16, element and bus data width.
AW, 16, address width.
UNIT_ID, 4'h2, value of address[AW-1:AW-4] this block decodes.

Ports:
Clk  in  1  system clock, all state on rising edge.
nReset  in  1  asynchronous active-low reset.
address  in  AW  [AW-1:AW-4] unit select; [11:8] bank (0=SRC1, 1=SRC2, 2=RESULT, 3=CTRL/STATUS); [7:0] element index row*N+col.
ExeDataOut  in  DW  write data from execution engine.
nWrite  in  1  active-low write strobe, sampled on Clk.
nRead  in  1  active-low read strobe, sampled on Clk.
MatrixDataOut  out  DW  registered read data.
Busy  out  1  operation in progress.
Done  out  1  sticky completion flag.

Behaviour:
- Select: access is valid only when address[AW-1:AW-4]==UNIT_ID and index<N*N (CTRL: index 0 only). Invalid accesses are ignored; reads of them return 0.
- Reset (async, nReset=0): all bank elements, MatrixDataOut, Busy, Done and Err go to 0; sequencer goes to IDLE. Mid-operation reset aborts immediately and the partial result is cleared.
- Writes:
  - nWrite=0 at an edge stores ExeDataOut into the addressed SRC1/SRC2 element.
  - RESULT bank is read-only.
  - While Busy=1, SRC writes are ignored.
- Reads:
  - nRead=0 at edge k loads MatrixDataOut at edge k; data is visible in cycle k+1.
  - MatrixDataOut holds its value otherwise.
  - nRead and nWrite both low: the write is performed and MatrixDataOut holds.
- CTRL write (bank 3, index 0): ExeDataOut[2:0] is the opcode: 0 ADD, 1 SUB, 2 MUL, 3 TRANSPOSE(SRC1), 4 SCALE(SRC1 × SRC2[0]).
  - Opcodes 5-7 set Err and do not start.
  - A CTRL write while Busy is ignored, including Err.
  - A legal CTRL write clears Done and Err, sets Busy, and moves the sequencer to RUN.
- STATUS read (bank 3, index 0): {.., Err, Done, Busy} in bits [2:0]; upper bits are 0.
- FSM: IDLE → RUN → (MAC for MUL) → FIN → IDLE.
  - Elementwise ops (ADD/SUB/TRANSPOSE/SCALE): element counter e=0..N*N-1, one RESULT element written per cycle.
    - Start write at edge k: element e is written at edge k+1+e.
    - Busy falls and Done rises at edge k+N*N.
  - MUL: for result element e (row i, col j), an inner counter m=0..N-1 accumulates SRC1[i][m]*SRC2[m][j].
    - Accumulator width is 2*DW+clog2(N) and is cleared at the start of each element.
    - Element e is written at edge k+(e+1)*N.
    - Busy falls and Done rises at edge k+N*N*N.
  - TRANSPOSE: RESULT[i][j]=SRC1[j][i].
- Arithmetic:
  - All values are unsigned two's-complement bit patterns.
  - ADD/SUB wrap modulo 2^DW.
  - SCALE and MUL take the low DW bits of the product or accumulator (wrap, no saturation).
- Done stays set until the next legal start or reset. RESULT holds its value until overwritten by the next op.
- Reads are allowed while Busy; RESULT elements not yet written show stale values.

Test Plan:
- Reset then STATUS read → MatrixDataOut=0x0000. Read SRC1[5] → 0x0000. Assert nReset mid-MUL → Busy=0, RESULT all 0.
- N=4: SRC1[e]=e, SRC2[e]=0x0010. CTRL=ADD at edge k → Busy high for exactly 16 cycles, Done at k+16, RESULT[e]=e+0x10. Repeat with SUB where SRC1[0]=0x0000, SRC2[0]=0x0001 → RESULT[0]=0xFFFF (wrap).
- MUL: SRC1 = identity, SRC2[e]=e+1 → RESULT[e]=e+1, Done at k+64. Then SRC1 all 0x0002, SRC2 all 0x0003 → every RESULT=0x0018.
- TRANSPOSE: SRC1[e]=e → RESULT[1]=4, RESULT[4]=1, RESULT[15]=15. SCALE with SRC2[0]=0x8000 and SRC1[0]=0x0003 → RESULT[0]=0x8000 (low bits).
- Illegal opcode 6 → STATUS=0b100, Busy stays 0. CTRL=ADD written while Busy → ignored, completion time unchanged. SRC write while Busy → SRC unchanged.
- Address miss: unit select 4'h3 or index 16 → no state change, read returns 0. Simultaneous nRead=nWrite=0 on SRC1[2] with data 0xABCD → SRC1[2]=0xABCD, MatrixDataOut unchanged.

Source files
------------

// File: rtl/matrix_alu_param.sv
// Bus-mapped N x N matrix ALU (ADD/SUB/MUL/TRANSPOSE/SCALE) with SRC1/SRC2/RESULT banks and CTRL/STATUS.
// Reads registered (1 cycle); elementwise ops take N*N cycles, MUL N*N*N; SRC/CTRL writes are dropped while Busy.
module matrix_alu_param #(
  parameter int         N       = 4,
  parameter int         DW      = 16,
  parameter int         AW      = 16,
  parameter logic [3:0] UNIT_ID = 4'h2
) (
  input  logic          Clk,
  input  logic          nReset,
  input  logic [AW-1:0] address,
  input  logic [DW-1:0] ExeDataOut,
  input  logic          nWrite,
  input  logic          nRead,
  output logic [DW-1:0] MatrixDataOut,
  output logic          Busy,
  output logic          Done
);
  localparam int NE   = N * N;
  localparam int IW   = $clog2(NE);
  localparam int CW   = $clog2(N);
  localparam int PW   = 2 * DW;
  localparam int ACCW = 2 * DW + CW;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_TRN = 3'd3;
  localparam logic [2:0] OP_SCL = 3'd4;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_MAC, S_FIN} state_t;

  state_t          r_state, w_state_nxt;
  logic [DW-1:0]   r_src1 [NE];
  logic [DW-1:0]   r_src2 [NE];
  logic [DW-1:0]   r_res  [NE];
  logic [DW-1:0]   r_rdata;
  logic            r_done, r_err;
  logic [2:0]      r_op;
  logic [CW-1:0]   r_i, r_j, r_m;
  logic [ACCW-1:0] r_acc;

  logic            w_unit_hit, w_idx_ok, w_src1_sel, w_src2_sel, w_res_sel, w_ctrl_sel;
  logic            w_busy, w_ctrl_wr, w_legal, w_start, w_last, w_elem_wr;
  logic [IW-1:0]   w_eidx, w_cur, w_tidx, w_aidx, w_bidx;
  logic [PW-1:0]   w_prod, w_scl;
  logic [ACCW-1:0] w_acc_sum;
  logic [DW-1:0]   w_res_val, w_rd_val;

  assign w_unit_hit = (address[AW-1:AW-4] == UNIT_ID);
  assign w_idx_ok   = ({1'b0, address[7:0]} < 9'(NE));
  assign w_eidx     = address[IW-1:0];
  assign w_src1_sel = w_unit_hit && w_idx_ok && (address[11:8] == 4'd0);
  assign w_src2_sel = w_unit_hit && w_idx_ok && (address[11:8] == 4'd1);
  assign w_res_sel  = w_unit_hit && w_idx_ok && (address[11:8] == 4'd2);
  assign w_ctrl_sel = w_unit_hit && (address[11:8] == 4'd3) && (address[7:0] == 8'd0);

  assign w_busy    = (r_state == S_RUN) || (r_state == S_MAC);
  assign w_ctrl_wr = !nWrite && w_ctrl_sel && !w_busy;
  assign w_legal   = (ExeDataOut[2:0] <= OP_SCL);
  assign w_start   = w_ctrl_wr && w_legal;
  assign w_last    = (r_i == CW'(N - 1)) && (r_j == CW'(N - 1));

  // Row/column counters drive all index arithmetic; no division needed.
  assign w_cur     = IW'(r_i) * IW'(N) + IW'(r_j);
  assign w_tidx    = IW'(r_j) * IW'(N) + IW'(r_i);
  assign w_aidx    = IW'(r_i) * IW'(N) + IW'(r_m);
  assign w_bidx    = IW'(r_m) * IW'(N) + IW'(r_j);
  assign w_prod    = PW'(r_src1[w_aidx]) * PW'(r_src2[w_bidx]);
  assign w_scl     = PW'(r_src1[w_cur]) * PW'(r_src2[0]);
  assign w_acc_sum = r_acc + ACCW'(w_prod);

  always_comb begin
    w_res_val = '0;
    case (r_op)
      OP_ADD:  w_res_val = r_src1[w_cur] + r_src2[w_cur];
      OP_SUB:  w_res_val = r_src1[w_cur] - r_src2[w_cur];
      OP_MUL:  w_res_val = w_acc_sum[DW-1:0];
      OP_TRN:  w_res_val = r_src1[w_tidx];
      OP_SCL:  w_res_val = w_scl[DW-1:0];
      default: w_res_val = '0;
    endcase
  end

  always_comb begin
    w_rd_val = '0;
    if (w_src1_sel)      w_rd_val = r_src1[w_eidx];
    else if (w_src2_sel) w_rd_val = r_src2[w_eidx];
    else if (w_res_sel)  w_rd_val = r_res[w_eidx];
    else if (w_ctrl_sel) w_rd_val = {{(DW-3){1'b0}}, r_err, r_done, w_busy};
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_elem_wr   = 1'b0;
    case (r_state)
      S_IDLE, S_FIN: begin
        w_state_nxt = S_IDLE;
        if (w_start) w_state_nxt = (ExeDataOut[2:0] == OP_MUL) ? S_MAC : S_RUN;
      end
      S_RUN: begin
        w_elem_wr = 1'b1;
        if (w_last) w_state_nxt = S_FIN;
      end
      S_MAC: begin
        if (r_m == CW'(N - 1)) begin
          w_elem_wr = 1'b1;
          if (w_last) w_state_nxt = S_FIN;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      for (int k = 0; k < NE; k++) begin
        r_src1[k] <= '0;
        r_src2[k] <= '0;
        r_res[k]  <= '0;
      end
      r_rdata <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_op    <= '0;
      r_i     <= '0;
      r_j     <= '0;
      r_m     <= '0;
      r_acc   <= '0;
    end else begin
      if (!nWrite && !w_busy && w_src1_sel) r_src1[w_eidx] <= ExeDataOut;
      if (!nWrite && !w_busy && w_src2_sel) r_src2[w_eidx] <= ExeDataOut;
      if (!nRead && nWrite) r_rdata <= w_rd_val;

      if (w_ctrl_wr) begin
        if (w_legal) begin
          r_op   <= ExeDataOut[2:0];
          r_done <= 1'b0;
          r_err  <= 1'b0;
          r_i    <= '0;
          r_j    <= '0;
          r_m    <= '0;
          r_acc  <= '0;
        end else begin
          r_err  <= 1'b1;
        end
      end

      if (w_elem_wr) begin
        r_res[w_cur] <= w_res_val;
        r_acc        <= '0;
        r_m          <= '0;
        if (r_j == CW'(N - 1)) begin
          r_j <= '0;
          r_i <= r_i + CW'(1);
        end else begin
          r_j <= r_j + CW'(1);
        end
        if (w_last) r_done <= 1'b1;
      end else if (r_state == S_MAC) begin
        r_acc <= w_acc_sum;
        r_m   <= r_m + CW'(1);
      end
    end
  end

  assign MatrixDataOut = r_rdata;
  assign Busy          = w_busy;
  assign Done          = r_done;
endmodule

// File: tb/tb_matrix_alu_param.sv
// Directed plus randomized bench for matrix_alu_param (N=4) against a plain-arithmetic matrix model.
module tb_matrix_alu_param;
  localparam int NN = 4;
  localparam int NE = NN * NN;

  logic        Clk = 1'b0;
  logic        nReset, nWrite, nRead;
  logic [15:0] address, ExeDataOut;
  logic [15:0] MatrixDataOut;
  logic        Busy, Done;

  int          n_vec  = 0;
  int          n_fail = 0;
  logic [15:0] m1 [NE];
  logic [15:0] m2 [NE];
  logic [15:0] mr [NE];

  matrix_alu_param #(.N(NN), .DW(16), .AW(16), .UNIT_ID(4'h2)) dut (
    .Clk(Clk), .nReset(nReset), .address(address), .ExeDataOut(ExeDataOut),
    .nWrite(nWrite), .nRead(nRead), .MatrixDataOut(MatrixDataOut),
    .Busy(Busy), .Done(Done)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] adr(input logic [3:0] unit, input logic [3:0] bank, input int idx);
    return {unit, bank, 8'(idx)};
  endfunction

  task automatic bus_wr(input logic [15:0] a, input logic [15:0] d);
    address = a; ExeDataOut = d; nWrite = 1'b0;
    @(negedge Clk);
    nWrite = 1'b1;
  endtask

  task automatic bus_rd(input logic [15:0] a, output logic [15:0] d);
    address = a; nRead = 1'b0;
    @(negedge Clk);
    nRead = 1'b1;
    d = MatrixDataOut;
  endtask

  task automatic rd_chk(input string tag, input logic [15:0] a, input logic [15:0] exp);
    logic [15:0] d;
    bus_rd(a, d);
    check(tag, 32'(d), 32'(exp));
  endtask

  task automatic wr_src(input int bank, input int idx, input logic [15:0] d);
    bus_wr(adr(4'h2, 4'(bank), idx), d);
    if (bank == 0) m1[idx] = d;
    else           m2[idx] = d;
  endtask

  // Reference: textbook matrix arithmetic, truncated to 16 bits at the end.
  task automatic model_calc(input logic [2:0] op);
    for (int i = 0; i < NN; i++) begin
      for (int j = 0; j < NN; j++) begin
        bit [63:0] s;
        s = 64'd0;
        case (op)
          3'd0: s = 64'(m1[i*NN+j]) + 64'(m2[i*NN+j]);
          3'd1: s = 64'(m1[i*NN+j]) - 64'(m2[i*NN+j]);
          3'd2: for (int k = 0; k < NN; k++) s += 64'(m1[i*NN+k]) * 64'(m2[k*NN+j]);
          3'd3: s = 64'(m1[j*NN+i]);
          default: s = 64'(m1[i*NN+j]) * 64'(m2[0]);
        endcase
        mr[i*NN+j] = s[15:0];
      end
    end
  endtask

  task automatic wait_idle(input string tag, input int cyc0, input int exp_cyc);
    int cyc;
    cyc = cyc0;
    while (Busy === 1'b1 && cyc < 1000) begin
      @(negedge Clk);
      cyc++;
    end
    check({tag, "_cycles"}, 32'(cyc), 32'(exp_cyc));
    check({tag, "_done"}, 32'(Done), 32'd1);
  endtask

  task automatic chk_results(input string tag);
    for (int e = 0; e < NE; e++)
      rd_chk($sformatf("%s_res%0d", tag, e), adr(4'h2, 4'd2, e), mr[e]);
  endtask

  task automatic run_op(input string tag, input logic [2:0] op);
    bus_wr(adr(4'h2, 4'd3, 0), {13'd0, op});
    wait_idle(tag, 0, (op == 3'd2) ? NE * NN : NE);
    model_calc(op);
    chk_results(tag);
  endtask

  initial begin
    logic [15:0] d;
    nReset = 1'b0; nWrite = 1'b1; nRead = 1'b1; address = '0; ExeDataOut = '0;
    for (int e = 0; e < NE; e++) begin m1[e] = '0; m2[e] = '0; mr[e] = '0; end
    repeat (3) @(negedge Clk);
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_done", 32'(Done), 32'd0);
    check("rst_rdata", 32'(MatrixDataOut), 32'd0);
    nReset = 1'b1;
    @(negedge Clk);
    rd_chk("rst_status", adr(4'h2, 4'd3, 0), 16'h0000);
    rd_chk("rst_src1_5", adr(4'h2, 4'd0, 5), 16'h0000);

    bus_wr(adr(4'h2, 4'd3, 0), 16'h0006);
    check("illegal_busy", 32'(Busy), 32'd0);
    rd_chk("illegal_status", adr(4'h2, 4'd3, 0), 16'h0004);

    for (int e = 0; e < NE; e++) begin wr_src(0, e, 16'(e)); wr_src(1, e, 16'h0010); end
    bus_wr(adr(4'h2, 4'd3, 0), 16'h0000);
    check("add_busy_rise", 32'(Busy), 32'd1);
    check("add_done_clr", 32'(Done), 32'd0);
    bus_wr(adr(4'h2, 4'd0, 3), 16'h7777);
    bus_wr(adr(4'h2, 4'd3, 0), 16'h0000);
    bus_wr(adr(4'h2, 4'd3, 0), 16'h0007);
    wait_idle("add", 3, NE);
    rd_chk("add_status", adr(4'h2, 4'd3, 0), 16'h0002);
    rd_chk("busy_src_wr", adr(4'h2, 4'd0, 3), 16'h0003);
    model_calc(3'd0);
    chk_results("add");

    wr_src(0, 0, 16'h0000); wr_src(1, 0, 16'h0001);
    run_op("sub", 3'd1);
    rd_chk("sub_wrap", adr(4'h2, 4'd2, 0), 16'hFFFF);

    for (int e = 0; e < NE; e++) begin
      wr_src(0, e, (e / NN == e % NN) ? 16'h0001 : 16'h0000);
      wr_src(1, e, 16'(e + 1));
    end
    run_op("mul_id", 3'd2);
    for (int e = 0; e < NE; e++) begin wr_src(0, e, 16'h0002); wr_src(1, e, 16'h0003); end
    run_op("mul_const", 3'd2);
    rd_chk("mul_const_r9", adr(4'h2, 4'd2, 9), 16'h0018);

    for (int e = 0; e < NE; e++) wr_src(0, e, 16'(e));
    run_op("trn", 3'd3);
    rd_chk("trn_r1", adr(4'h2, 4'd2, 1), 16'd4);
    rd_chk("trn_r4", adr(4'h2, 4'd2, 4), 16'd1);
    rd_chk("trn_r15", adr(4'h2, 4'd2, 15), 16'd15);

    wr_src(1, 0, 16'h8000); wr_src(0, 0, 16'h0003);
    run_op("scl", 3'd4);
    rd_chk("scl_r0", adr(4'h2, 4'd2, 0), 16'h8000);

    for (int r = 0; r < 5; r++) begin
      for (int e = 0; e < NE; e++) begin
        wr_src(0, e, 16'($urandom));
        wr_src(1, e, 16'($urandom));
      end
      run_op($sformatf("rnd%0d", r), 3'($urandom_range(0, 4)));
    end

    bus_wr(adr(4'h3, 4'd0, 2), 16'h1234);
    rd_chk("miss_unit_rd", adr(4'h3, 4'd0, 2), 16'h0000);
    bus_wr(adr(4'h2, 4'd0, 16), 16'h5678);
    rd_chk("miss_idx_rd", adr(4'h2, 4'd0, 16), 16'h0000);
    bus_wr(adr(4'h3, 4'd3, 0), 16'h0000);
    check("miss_ctrl_busy", 32'(Busy), 32'd0);
    bus_wr(adr(4'h2, 4'd2, 0), 16'hDEAD);
    rd_chk("res_readonly", adr(4'h2, 4'd2, 0), mr[0]);
    for (int e = 0; e < NE; e++)
      rd_chk($sformatf("miss_src1_%0d", e), adr(4'h2, 4'd0, e), m1[e]);

    wr_src(0, 1, 16'h1111); wr_src(0, 2, 16'h2222);
    rd_chk("simul_pre", adr(4'h2, 4'd0, 1), 16'h1111);
    address = adr(4'h2, 4'd0, 2); ExeDataOut = 16'hABCD; nWrite = 1'b0; nRead = 1'b0;
    @(negedge Clk);
    nWrite = 1'b1; nRead = 1'b1;
    check("simul_hold", 32'(MatrixDataOut), 32'h1111);
    rd_chk("simul_wr", adr(4'h2, 4'd0, 2), 16'hABCD);

    bus_wr(adr(4'h2, 4'd3, 0), 16'h0002);
    repeat (10) @(negedge Clk);
    check("midrst_pre_busy", 32'(Busy), 32'd1);
    nReset = 1'b0;
    #1;
    check("midrst_busy", 32'(Busy), 32'd0);
    check("midrst_done", 32'(Done), 32'd0);
    @(negedge Clk);
    nReset = 1'b1;
    @(negedge Clk);
    for (int e = 0; e < NE; e++)
      rd_chk($sformatf("midrst_res%0d", e), adr(4'h2, 4'd2, e), 16'h0000);
    rd_chk("midrst_status", adr(4'h2, 4'd3, 0), 16'h0000);
    bus_rd(adr(4'h2, 4'd0, 2), d);
    check("midrst_src1_2", 32'(d), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
